// File: rtl/pc_gen_way1.sv
// pc_gen_way1: way-1 program counter and fetch-request generator.
// Issues one fetch at a time and marks wrong-path responses after a redirect.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   stall_i        backend stall, holds pc and blocks new requests
//   jumpFlag_i     one-cycle redirect request
//   jumpAddr_i     redirect target (low two bits are dropped)
//   dataOk_i       memory response for the outstanding request
//   valid_o        fetch request to the fetch unit
//   instAddr_o     fetch address (current pc)
//   discard_o      this cycle's dataOk_i belongs to a flushed request
//   misalign_o     one-cycle pulse after a jump target with [1:0] != 0
//   fetchCnt_o     accepted responses, saturating   (FETCH_PERF_EN only)
//   flushCnt_o     discarded responses, saturating  (FETCH_PERF_EN only)
//
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.

module pc_gen_way1 #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned INST_BYTES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        jumpFlag_i,
    input  logic [31:0] jumpAddr_i,
    input  logic        dataOk_i,
    output logic        valid_o,
    output logic [31:0] instAddr_o,
    output logic        discard_o,
    output logic        misalign_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetchCnt_o,
    output logic [15:0] flushCnt_o
`endif
);

    localparam logic [31:0] PC_INC = 32'(INST_BYTES);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        jump_taken;

    assign target = {jumpAddr_i[31:2], 2'b00};
    assign pc_inc = pc_q + PC_INC;

    // A jump is honoured in every state except BOOT, where no pc
    // has been issued yet and the reset address always goes first.
    assign jump_taken = jumpFlag_i && (state_q != BOOT);

    // State register: fsm state, pc and the misalign pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_o <= jump_taken && (jumpAddr_i[1:0] != 2'b00);
        end
    end

    // Next-state and next-pc logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                // Jump has priority over stall. A jump that arrives
                // together with the response flushes it in place; a
                // jump without it leaves a stale response in flight.
                if (dataOk_i && jumpFlag_i) begin
                    pc_d = target;
                end else if (dataOk_i && stall_i) begin
                    pc_d    = pc_inc;
                    state_d = HOLD;
                end else if (dataOk_i) begin
                    pc_d = pc_inc;
                end else if (jumpFlag_i) begin
                    pc_d    = target;
                    state_d = DISCARD;
                end
            end
            HOLD: begin
                // Nothing is outstanding here, so dataOk_i is ignored.
                if (jumpFlag_i) begin
                    pc_d = target;
                end
                if (!stall_i) begin
                    state_d = REQ;
                end
            end
            DISCARD: begin
                // Latest redirect wins, even on the flush cycle.
                if (jumpFlag_i) begin
                    pc_d = target;
                end
                if (dataOk_i) begin
                    state_d = stall_i ? HOLD : REQ;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        valid_o    = (state_q == REQ);
        instAddr_o = pc_q;
        discard_o  = 1'b0;
        unique case (state_q)
            REQ:     discard_o = dataOk_i && jumpFlag_i;
            DISCARD: discard_o = dataOk_i;
            default: discard_o = 1'b0;
        endcase
    end

`ifdef FETCH_PERF_EN
    logic resp_live;
    logic fetch_hit;
    logic flush_hit;

    // Only responses to a real outstanding request are counted.
    assign resp_live = dataOk_i
                    && ((state_q == REQ) || (state_q == DISCARD));
    assign fetch_hit = resp_live && !discard_o;
    assign flush_hit = resp_live && discard_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchCnt_o <= '0;
            flushCnt_o <= '0;
        end else begin
            if (fetch_hit && (fetchCnt_o != '1)) begin
                fetchCnt_o <= fetchCnt_o + 32'd1;
            end
            if (flush_hit && (flushCnt_o != '1)) begin
                flushCnt_o <= flushCnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen_way1.sv
// tb_pc_gen_way1: directed self-checking bench for pc_gen_way1.
// Inputs change on the falling edge; outputs are checked 1ns later.

module tb_pc_gen_way1;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        jumpFlag_i;
    logic [31:0] jumpAddr_i;
    logic        dataOk_i;
    logic        valid_o;
    logic [31:0] instAddr_o;
    logic        discard_o;
    logic        misalign_o;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCnt_o;
    logic [15:0] flushCnt_o;
`endif

    int checks = 0;
    int errors = 0;

    pc_gen_way1 dut (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (stall_i),
        .jumpFlag_i (jumpFlag_i),
        .jumpAddr_i (jumpAddr_i),
        .dataOk_i   (dataOk_i),
        .valid_o    (valid_o),
        .instAddr_o (instAddr_o),
        .discard_o  (discard_o),
        .misalign_o (misalign_o)
`ifdef FETCH_PERF_EN
        ,
        .fetchCnt_o (fetchCnt_o),
        .flushCnt_o (flushCnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic st,
                         input logic jf, input logic [31:0] ja,
                         input logic ok);
        @(negedge clk);
        reset      = rst;
        stall_i    = st;
        jumpFlag_i = jf;
        jumpAddr_i = ja;
        dataOk_i   = ok;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b exp 0", valid_o);
        end
        checks++;
        if (discard_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard got %b exp 0", discard_o);
        end
        checks++;
        if (misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_misalign got %b exp 0", misalign_o);
        end
        checks++;
        if (instAddr_o !== 32'h8000_0000) begin
            errors++;
            $display("FAIL reset_addr got %h exp 80000000", instAddr_o);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (fetchCnt_o !== 32'd0 || flushCnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0",
                     fetchCnt_o, flushCnt_o);
        end
`endif
    endtask

    task automatic test_startup();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL boot_c1_valid got %b exp 0", valid_o);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (valid_o !== 1'b1 || instAddr_o !== 32'h8000_0000) begin
                errors++;
                $display("FAIL boot_req%0d got %b/%h exp 1/80000000",
                         i, valid_o, instAddr_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr;
        exp_addr = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1);
            checks++;
            if (valid_o !== 1'b1 || instAddr_o !== exp_addr
                || discard_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b%0d got %b/%h/%b exp 1/%h/0",
                         i, valid_o, instAddr_o, discard_o, exp_addr);
            end
            exp_addr = exp_addr + 32'd4;
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (valid_o !== 1'b1 || instAddr_o !== 32'h8000_000C) begin
            errors++;
            $display("FAIL b2b_last got %b/%h exp 1/8000000c",
                     valid_o, instAddr_o);
        end
    endtask

    task automatic test_jump_with_ok();
        drive(0, 0, 1, 32'h8000_0100, 1);
        checks++;
        if (discard_o !== 1'b1) begin
            errors++;
            $display("FAIL jok_discard got %b exp 1", discard_o);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (valid_o !== 1'b1 || instAddr_o !== 32'h8000_0100) begin
            errors++;
            $display("FAIL jok_target got %b/%h exp 1/80000100",
                     valid_o, instAddr_o);
        end
    endtask

    task automatic test_jump_pending();
        drive(0, 0, 1, 32'h8000_0200, 0);
        checks++;
        if (discard_o !== 1'b0) begin
            errors++;
            $display("FAIL jpend_disc0 got %b exp 0", discard_o);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (valid_o !== 1'b0) begin
                errors++;
                $display("FAIL jpend_idle%0d got %b exp 0", i, valid_o);
            end
        end
        drive(0, 0, 0, 0, 1);
        checks++;
        if (valid_o !== 1'b0 || discard_o !== 1'b1) begin
            errors++;
            $display("FAIL jpend_flush got %b/%b exp 0/1",
                     valid_o, discard_o);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (valid_o !== 1'b1 || instAddr_o !== 32'h8000_0200) begin
            errors++;
            $display("FAIL jpend_target got %b/%h exp 1/80000200",
                     valid_o, instAddr_o);
        end
    endtask

    task automatic test_stall();
        drive(0, 1, 0, 0, 1);
        checks++;
        if (discard_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_disc got %b exp 0", discard_o);
        end
        drive(0, 1, 1, 32'h8000_0203, 0);
        checks++;
        if (valid_o !== 1'b0 || instAddr_o !== 32'h8000_0204) begin
            errors++;
            $display("FAIL stall_hold got %b/%h exp 0/80000204",
                     valid_o, instAddr_o);
        end
        drive(0, 1, 0, 0, 0);
        checks++;
        if (misalign_o !== 1'b1 || valid_o !== 1'b0
            || instAddr_o !== 32'h8000_0200) begin
            errors++;
            $display("FAIL stall_mis1 got %b/%b/%h exp 1/0/80000200",
                     misalign_o, valid_o, instAddr_o);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (misalign_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_mis0 got %b/%b exp 0/0",
                     misalign_o, valid_o);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (valid_o !== 1'b1 || instAddr_o !== 32'h8000_0200) begin
            errors++;
            $display("FAIL stall_rel got %b/%h exp 1/80000200",
                     valid_o, instAddr_o);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf_counters();
        checks++;
        if (fetchCnt_o !== 32'd4 || flushCnt_o !== 16'd2) begin
            errors++;
            $display("FAIL perf_cnt got %0d/%0d exp 4/2",
                     fetchCnt_o, flushCnt_o);
        end
    endtask
`endif

    task automatic test_wrap();
        drive(0, 0, 1, 32'hFFFF_FFFC, 1);
        drive(0, 0, 0, 0, 1);
        checks++;
        if (valid_o !== 1'b1 || instAddr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_top got %b/%h exp 1/fffffffc",
                     valid_o, instAddr_o);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (valid_o !== 1'b1 || instAddr_o !== 32'h0000_0000
            || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_zero got %b/%h/%b exp 1/00000000/0",
                     valid_o, instAddr_o, misalign_o);
        end
    endtask

    task automatic test_discard_retarget();
        drive(0, 0, 1, 32'h8000_0400, 0);
        drive(0, 0, 1, 32'h8000_0500, 1);
        checks++;
        if (valid_o !== 1'b0 || discard_o !== 1'b1
            || instAddr_o !== 32'h8000_0400) begin
            errors++;
            $display("FAIL retgt_flush got %b/%b/%h exp 0/1/80000400",
                     valid_o, discard_o, instAddr_o);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (valid_o !== 1'b1 || instAddr_o !== 32'h8000_0500) begin
            errors++;
            $display("FAIL retgt_new got %b/%h exp 1/80000500",
                     valid_o, instAddr_o);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        checks++;
        if (valid_o !== 1'b0 || discard_o !== 1'b0
            || instAddr_o !== 32'h8000_0000) begin
            errors++;
            $display("FAIL rmid_boot got %b/%b/%h exp 0/0/80000000",
                     valid_o, discard_o, instAddr_o);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (valid_o !== 1'b1 || instAddr_o !== 32'h8000_0000) begin
            errors++;
            $display("FAIL rmid_req got %b/%h exp 1/80000000",
                     valid_o, instAddr_o);
        end
    endtask

    initial begin
        reset      = 1'b1;
        stall_i    = 1'b0;
        jumpFlag_i = 1'b0;
        jumpAddr_i = 32'd0;
        dataOk_i   = 1'b0;
        test_reset();
        test_startup();
        test_back_to_back();
        test_jump_with_ok();
        test_jump_pending();
        test_stall();
`ifdef FETCH_PERF_EN
        test_perf_counters();
`endif
        test_wrap();
        test_discard_retarget();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
